// File: rtl/rs_age_matrix.sv
// rs_age_matrix: reservation station for one FU class. Multiple dispatches and
// multiple oldest-first issues per cycle. Relative age lives in an age matrix
// (age_q[i][j] = 1 means entry j is older than entry i), so selection never
// compares wrapping ROB indices. Sources can be woken by broadcast tags,
// including a bypass for tags that arrive in the same cycle as dispatch.
module rs_age_matrix #(
    parameter int DEPTH          = 8,
    parameter int DISPATCH_WIDTH = 2,
    parameter int ISSUE_WIDTH    = 2,
    parameter int NUM_SRC        = 2,
    parameter int WB_WIDTH       = 4,
    parameter int TAG_W          = 7,
    parameter int PAYLOAD_W      = 64
) (
    input  logic                                    clk,
    input  logic                                    a_rst,
    input  logic                                    flush_i,
    input  logic [DISPATCH_WIDTH-1:0]               disp_valid_i,
    output logic [DISPATCH_WIDTH-1:0]               disp_ready_o,
    input  logic [DISPATCH_WIDTH*NUM_SRC*TAG_W-1:0] disp_src_tag_i,
    input  logic [DISPATCH_WIDTH*NUM_SRC-1:0]       disp_src_valid_i,
    input  logic [DISPATCH_WIDTH*NUM_SRC-1:0]       disp_src_ready_i,
    input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0]     disp_payload_i,
    input  logic [WB_WIDTH-1:0]                     wb_valid_i,
    input  logic [WB_WIDTH*TAG_W-1:0]               wb_tag_i,
    output logic [ISSUE_WIDTH-1:0]                  issue_valid_o,
    input  logic [ISSUE_WIDTH-1:0]                  issue_ready_i,
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0]        issue_payload_o,
    output logic [$clog2(DEPTH+1)-1:0]              occupancy_o
);
    localparam int OCC_W  = $clog2(DEPTH+1);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PORT_W = $clog2(DISPATCH_WIDTH+1);

    // Registered state
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [NUM_SRC-1:0]   src_rdy_q [DEPTH];
    logic [NUM_SRC-1:0]   src_rdy_d [DEPTH];
    logic [TAG_W-1:0]     src_tag_q [DEPTH][NUM_SRC];
    logic [TAG_W-1:0]     src_tag_d [DEPTH][NUM_SRC];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [DEPTH-1:0]     age_q [DEPTH];
    logic [DEPTH-1:0]     age_d [DEPTH];
    logic [OCC_W-1:0]     occ_q, occ_d;

    // Combinational helpers
    logic [OCC_W-1:0]          free_cnt;
    logic [IDX_W-1:0]          free_idx [DISPATCH_WIDTH];
    logic [DISPATCH_WIDTH-1:0] disp_acc;
    logic [NUM_SRC-1:0]        src_hit [DEPTH];
    logic [NUM_SRC-1:0]        disp_hit [DISPATCH_WIDTH];
    logic [DEPTH-1:0]          rdy;
    logic [OCC_W-1:0]          rank [DEPTH];
    logic [DEPTH-1:0]          sel [ISSUE_WIDTH];
    logic [DEPTH-1:0]          issued;
    logic [DEPTH-1:0]          wr_en;
    logic [PORT_W-1:0]         wr_port [DEPTH];

    function automatic logic [OCC_W-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + OCC_W'(v[i]);
        end
        return c;
    endfunction

    // Free-slot count and the lowest DISPATCH_WIDTH free indices, from registered valids
    always_comb begin
        int n;
        n = 0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            free_idx[k] = '0;
        end
        for (int e = 0; e < DEPTH; e++) begin
            if (!valid_q[e]) begin
                for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                    if (n == k) begin
                        free_idx[k] = IDX_W'(e);
                    end
                end
                n = n + 1;
            end
        end
        free_cnt = OCC_W'(n);
    end

    // Ready is a thermometer: port k can go only if more than k slots are free
    for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_dready
        assign disp_ready_o[gi] = (free_cnt > OCC_W'(gi)) & ~flush_i & ~a_rst;
    end
    assign disp_acc = disp_valid_i & disp_ready_o;

    // Tag match of every broadcast port against stored and dispatching sources
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            src_hit[e] = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                for (int w = 0; w < WB_WIDTH; w++) begin
                    if (wb_valid_i[w] && (wb_tag_i[w*TAG_W +: TAG_W] == src_tag_q[e][s])) begin
                        src_hit[e][s] = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            disp_hit[k] = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                for (int w = 0; w < WB_WIDTH; w++) begin
                    if (wb_valid_i[w] &&
                        (wb_tag_i[w*TAG_W +: TAG_W] == disp_src_tag_i[(k*NUM_SRC+s)*TAG_W +: TAG_W])) begin
                        disp_hit[k][s] = 1'b1;
                    end
                end
            end
        end
    end

    // An entry is a candidate when valid with every source ready (registered state only)
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
        assign rdy[gi] = valid_q[gi] & (&src_rdy_q[gi]);
    end

    // Rank = number of ready entries older than this one; rank p goes to issue port p
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            rank[e] = popcnt(age_q[e] & rdy);
        end
    end

    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_port
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_ent
            assign sel[gi][gj] = rdy[gj] & (rank[gj] == OCC_W'(gi));
        end
        assign issue_valid_o[gi] = (|sel[gi]) & ~flush_i & ~a_rst;
    end

    // Issue payload mux (one-hot select) and the set of entries leaving this cycle
    always_comb begin
        logic [PAYLOAD_W-1:0] acc;
        issue_payload_o = '0;
        issued          = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            acc = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (sel[p][e]) begin
                    acc = acc | payload_q[e];
                end
            end
            if (issue_valid_o[p]) begin
                issue_payload_o[p*PAYLOAD_W +: PAYLOAD_W] = acc;
                if (issue_ready_i[p]) begin
                    issued = issued | sel[p];
                end
            end
        end
    end

    // Next state: wakeup, issue retirement, dispatch writes, age update, flush
    always_comb begin
        int j;
        logic [IDX_W-1:0] slot;
        j       = 0;
        slot    = '0;
        valid_d = valid_q & ~issued;
        wr_en   = '0;
        for (int e = 0; e < DEPTH; e++) begin
            src_rdy_d[e] = src_rdy_q[e] | src_hit[e];
            payload_d[e] = payload_q[e];
            wr_port[e]   = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                src_tag_d[e][s] = src_tag_q[e][s];
            end
        end
        // j-th accepted port takes the j-th lowest free slot, so gaps are allowed
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (disp_acc[k]) begin
                slot            = free_idx[j];
                wr_en[slot]     = 1'b1;
                wr_port[slot]   = PORT_W'(k);
                valid_d[slot]   = 1'b1;
                payload_d[slot] = disp_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
                for (int s = 0; s < NUM_SRC; s++) begin
                    src_tag_d[slot][s] = disp_src_tag_i[(k*NUM_SRC+s)*TAG_W +: TAG_W];
                    src_rdy_d[slot][s] = ~disp_src_valid_i[k*NUM_SRC+s]
                                       | disp_src_ready_i[k*NUM_SRC+s]
                                       | disp_hit[k][s];
                end
                j = j + 1;
            end
        end
        // New rows see all resident entries and lower-port writes as older;
        // existing rows learn that freshly written entries are younger.
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            for (int c = 0; c < DEPTH; c++) begin
                if (wr_en[i]) begin
                    age_d[i][c] = valid_q[c] | (wr_en[c] & (wr_port[c] < wr_port[i]));
                end else if (wr_en[c]) begin
                    age_d[i][c] = 1'b0;
                end
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
        occ_d = popcnt(valid_d);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                src_rdy_q[e] <= '0;
                payload_q[e] <= '0;
                age_q[e]     <= '0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    src_tag_q[e][s] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int e = 0; e < DEPTH; e++) begin
                src_rdy_q[e] <= src_rdy_d[e];
                payload_q[e] <= payload_d[e];
                age_q[e]     <= age_d[e];
                for (int s = 0; s < NUM_SRC; s++) begin
                    src_tag_q[e][s] <= src_tag_d[e][s];
                end
            end
        end
    end

    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_rs_age_matrix.sv
// Directed, table-driven bench for rs_age_matrix with default parameters.
module tb_rs_age_matrix;
    localparam int DEPTH = 8;
    localparam int DW    = 2;
    localparam int IW    = 2;
    localparam int NS    = 2;
    localparam int WB    = 4;
    localparam int TW    = 7;
    localparam int PW    = 64;
    localparam int NV    = 17;

    logic               clk;
    logic               a_rst;
    logic               flush_i;
    logic [DW-1:0]      disp_valid_i;
    logic [DW-1:0]      disp_ready_o;
    logic [DW*NS*TW-1:0] disp_src_tag_i;
    logic [DW*NS-1:0]   disp_src_valid_i;
    logic [DW*NS-1:0]   disp_src_ready_i;
    logic [DW*PW-1:0]   disp_payload_i;
    logic [WB-1:0]      wb_valid_i;
    logic [WB*TW-1:0]   wb_tag_i;
    logic [IW-1:0]      issue_valid_o;
    logic [IW-1:0]      issue_ready_i;
    logic [IW*PW-1:0]   issue_payload_o;
    logic [3:0]         occupancy_o;

    rs_age_matrix #(
        .DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW), .NUM_SRC(NS),
        .WB_WIDTH(WB), .TAG_W(TW), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .a_rst(a_rst), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_src_tag_i(disp_src_tag_i), .disp_src_valid_i(disp_src_valid_i),
        .disp_src_ready_i(disp_src_ready_i), .disp_payload_i(disp_payload_i),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_payload_o(issue_payload_o), .occupancy_o(occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // One cycle of stimulus plus the outputs expected in that same cycle
    typedef struct packed {
        logic [1:0] dv;
        logic [6:0] t0;
        logic [6:0] t1;
        logic [1:0] r;
        logic [7:0] pl0;
        logic [7:0] pl1;
        logic [3:0] wbv;
        logic [6:0] wbt;
        logic [1:0] ir;
        logic       fl;
        logic [1:0] e_dr;
        logic [1:0] e_iv;
        logic [7:0] e_p0;
        logic [7:0] e_p1;
        logic [3:0] e_occ;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mkv(
        input logic [1:0] dv, input logic [6:0] t0, input logic [6:0] t1, input logic [1:0] r,
        input logic [7:0] pl0, input logic [7:0] pl1, input logic [3:0] wbv, input logic [6:0] wbt,
        input logic [1:0] ir, input logic fl, input logic [1:0] e_dr, input logic [1:0] e_iv,
        input logic [7:0] e_p0, input logic [7:0] e_p1, input logic [3:0] e_occ);
        vec_t v;
        v.dv = dv; v.t0 = t0; v.t1 = t1; v.r = r; v.pl0 = pl0; v.pl1 = pl1;
        v.wbv = wbv; v.wbt = wbt; v.ir = ir; v.fl = fl;
        v.e_dr = e_dr; v.e_iv = e_iv; v.e_p0 = e_p0; v.e_p1 = e_p1; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        flush_i          = v.fl;
        disp_valid_i     = v.dv;
        disp_src_tag_i   = '0;
        disp_src_valid_i = '0;
        disp_src_ready_i = '0;
        disp_payload_i   = '0;
        disp_src_tag_i[0 +: TW]     = v.t0;
        disp_src_tag_i[NS*TW +: TW] = v.t1;
        disp_src_valid_i[0]  = v.dv[0];
        disp_src_valid_i[NS] = v.dv[1];
        disp_src_ready_i[0]  = v.r[0];
        disp_src_ready_i[NS] = v.r[1];
        disp_payload_i[0 +: PW]  = {56'h0, v.pl0};
        disp_payload_i[PW +: PW] = {56'h0, v.pl1};
        wb_valid_i = v.wbv;
        for (int w = 0; w < WB; w++) begin
            wb_tag_i[w*TW +: TW] = v.wbt;
        end
        issue_ready_i = v.ir;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] dr, input logic [1:0] iv,
                              input logic [7:0] p0, input logic [7:0] p1, input logic [3:0] occ);
        $display("%s: dr=%b iv=%b p0=%0h p1=%0h occ=%0d", nm, disp_ready_o, issue_valid_o,
                 issue_payload_o[0 +: PW], issue_payload_o[PW +: PW], occupancy_o);
        chk({nm, " disp_ready"},  64'(disp_ready_o), 64'(dr));
        chk({nm, " issue_valid"}, 64'(issue_valid_o), 64'(iv));
        chk({nm, " payload0"},    issue_payload_o[0 +: PW], {56'h0, p0});
        chk({nm, " payload1"},    issue_payload_o[PW +: PW], {56'h0, p1});
        chk({nm, " occupancy"},   64'(occupancy_o), 64'(occ));
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        drive(v);
        @(negedge clk);
        expect_out(nm, v.e_dr, v.e_iv, v.e_p0, v.e_p1, v.e_occ);
        @(posedge clk);
        #1;
    endtask

    vec_t idle;

    initial begin
        idle = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0,
                   2'b00, 2'b00, 8'h00, 8'h00, 4'd0);

        // dv, t0, t1, r, pl0, pl1, wbv, wbt, ir, fl | dr, iv, p0, p1, occ
        // two ready entries issue next cycle, occupancy 0->2->0
        tbl[0]  = mkv(2'b11, 7'd5, 7'd6, 2'b11, 8'h10, 8'h11, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0);
        tbl[1]  = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b11, 1'b0, 2'b11, 2'b11, 8'h10, 8'h11, 4'd2);
        tbl[2]  = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0);
        // fill all 8 entries waiting on tag 9
        tbl[3]  = mkv(2'b11, 7'd9, 7'd9, 2'b00, 8'h20, 8'h21, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0);
        tbl[4]  = mkv(2'b11, 7'd9, 7'd9, 2'b00, 8'h22, 8'h23, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd2);
        tbl[5]  = mkv(2'b11, 7'd9, 7'd9, 2'b00, 8'h24, 8'h25, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd4);
        tbl[6]  = mkv(2'b11, 7'd9, 7'd9, 2'b00, 8'h26, 8'h27, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd6);
        tbl[7]  = mkv(2'b11, 7'd9, 7'd9, 2'b00, 8'h28, 8'h29, 4'h0, 7'd0, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 4'd8);
        // wake tag 9; full station stays closed even during the issue cycle
        tbl[8]  = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h4, 7'd9, 2'b00, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 4'd8);
        tbl[9]  = mkv(2'b11, 7'd9, 7'd9, 2'b00, 8'h28, 8'h29, 4'h0, 7'd0, 2'b11, 1'b0, 2'b00, 2'b11, 8'h20, 8'h21, 4'd8);
        tbl[10] = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b11, 1'b0, 2'b11, 2'b11, 8'h22, 8'h23, 4'd6);
        tbl[11] = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b11, 1'b0, 2'b11, 2'b11, 8'h24, 8'h25, 4'd4);
        tbl[12] = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b11, 1'b0, 2'b11, 2'b11, 8'h26, 8'h27, 4'd2);
        tbl[13] = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0);
        // dispatch-time wakeup bypass (duplicate tag on wb ports 0 and 3)
        tbl[14] = mkv(2'b01, 7'd12, 7'd0, 2'b00, 8'h30, 8'h00, 4'h9, 7'd12, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0);
        tbl[15] = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b01, 1'b0, 2'b11, 2'b01, 8'h30, 8'h00, 4'd1);
        tbl[16] = mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0);

        // reset state
        a_rst = 1'b1;
        drive(idle);
        @(posedge clk);
        #1;
        expect_out("reset", 2'b00, 2'b00, 8'h00, 8'h00, 4'd0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("v%0d", i), tbl[i]);
        end

        // non-sticky select: younger ready entry held, older one wakes and displaces it
        run_vec("h4_c0", mkv(2'b01, 7'd20, 7'd0, 2'b00, 8'h40, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0));
        run_vec("h4_c1", mkv(2'b10, 7'd0, 7'd21, 2'b10, 8'h00, 8'h41, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd1));
        run_vec("h4_c2", mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b01, 8'h41, 8'h00, 4'd2));
        run_vec("h4_c3", mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b01, 8'h41, 8'h00, 4'd2));
        run_vec("h4_c4", mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h2, 7'd20, 2'b00, 1'b0, 2'b11, 2'b01, 8'h41, 8'h00, 4'd2));
        run_vec("h4_c5", mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b11, 1'b0, 2'b11, 2'b11, 8'h40, 8'h41, 4'd2));
        run_vec("h4_c6", mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0));

        // flush at occupancy 5 with concurrent dispatch, issue and wakeup
        run_vec("h5_c0", mkv(2'b11, 7'd1, 7'd2, 2'b11, 8'h50, 8'h51, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0));
        run_vec("h5_c1", mkv(2'b11, 7'd30, 7'd30, 2'b00, 8'h52, 8'h53, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b11, 8'h50, 8'h51, 4'd2));
        run_vec("h5_c2", mkv(2'b10, 7'd0, 7'd30, 2'b00, 8'h00, 8'h54, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b11, 8'h50, 8'h51, 4'd4));
        run_vec("h5_flush", mkv(2'b11, 7'd3, 7'd4, 2'b11, 8'h55, 8'h56, 4'h1, 7'd30, 2'b11, 1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 4'd5));
        run_vec("h5_c4", mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0));
        run_vec("h5_c5", mkv(2'b00, 7'd0, 7'd0, 2'b00, 8'h00, 8'h00, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0));

        // asynchronous reset in the middle of a cycle with 4 entries resident
        run_vec("h6_c0", mkv(2'b11, 7'd1, 7'd2, 2'b11, 8'h60, 8'h61, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 4'd0));
        run_vec("h6_c1", mkv(2'b11, 7'd1, 7'd2, 2'b11, 8'h62, 8'h63, 4'h0, 7'd0, 2'b00, 1'b0, 2'b11, 2'b11, 8'h60, 8'h61, 4'd2));
        drive(idle);
        @(negedge clk);
        expect_out("h6_c2", 2'b11, 2'b11, 8'h60, 8'h61, 4'd4);
        #1;
        a_rst = 1'b1;
        drive(mkv(2'b11, 7'd1, 7'd2, 2'b11, 8'h64, 8'h65, 4'h0, 7'd0, 2'b11, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 4'd0));
        #1;
        expect_out("h6_rst_now", 2'b00, 2'b00, 8'h00, 8'h00, 4'd0);
        @(posedge clk);
        #1;
        expect_out("h6_rst_edge", 2'b00, 2'b00, 8'h00, 8'h00, 4'd0);
        drive(idle);
        a_rst = 1'b0;
        @(negedge clk);
        expect_out("h6_post0", 2'b11, 2'b00, 8'h00, 8'h00, 4'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        expect_out("h6_post1", 2'b11, 2'b00, 8'h00, 8'h00, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
